mips_mc_controller: RTL and testbench
=====================================

Name: mips_mc_controller

Overview:
- Multicycle control FSM for the MIPS datapath with a shared instruction/data memory.
- Sequences one instruction over 3-5 states: fetch, decode, execute, memory, writeback.
- Drives the mux selects, register/PC/IR enables and ALU function for that datapath.
- Handshakes with the shared memory through mem_req/mem_ready; counts retired instructions; traps illegal opcodes.

Parameters:
CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
op  input  6  IR[31:26], stable from the DECODE state until instruction end
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag (combinational, current cycle)
mem_ready  input  1  memory completes the access this cycle
mem_req  output  1  memory access request
memwrite  output  1  write strobe, qualified by mem_ready
iord  output  1  memory address select: 0=PC, 1=ALUOut
irwrite  output  1  IR load enable
pcen  output  1  PC load enable
pcsrc  output  2  00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],00}
alusrca  output  1  0=PC, 1=reg A
alusrcb  output  2  00=reg B, 01=const 4, 10=signimm, 11=signimm<<2
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
regdst  output  1  0=rt, 1=rd
memtoreg  output  1  0=ALUOut, 1=data register
regwrite  output  1  register file write enable
illegal_op  output  1  sticky trap flag
instr_count  output  CNT_W  retired-instruction count
state_o  output  4  current state encoding, for debug

Behaviour:
- Reset (async): state=IDLE, instr_count=0, illegal_op=0.
- All outputs are Moore-decoded from state, except pcen and irwrite, which also depend on mem_ready/zero.
- Outputs not listed for a state are 0; alucontrol defaults to 010.
- IDLE: all 0 -> FETCH.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - mem_ready=1: irwrite=1, pcen=1 -> DECODE.
  - mem_ready=0: hold FETCH with no enables.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE if funct is in {100000, 100010, 100100, 100101, 101010}, else ILLEGAL
  - 000100 -> BRANCH
  - 001000 -> ADDIEXEC
  - 000010 -> JUMP
  - any other op -> ILLEGAL
- MEMADR: alusrca=1, alusrcb=10, add -> MEMRD (LW) or MEMWR (SW).
- MEMRD: mem_req=1, iord=1; hold until mem_ready -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1; hold until mem_ready -> FETCH.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol decoded from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt) -> ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero -> FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, add -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JUMP: pcsrc=10, pcen=1 -> FETCH.
- ILLEGAL: illegal_op=1, all enables 0, mem_req=0. Absorbing; only reset exits.
- instr_count: +1 on every transition from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP into FETCH.
  - A BRANCH counts whether or not it is taken.
  - Wraps to 0 past its maximum.
- Latency with mem_ready tied 1: J 3, BEQ 3, R-type 4, ADDI 4, SW 4, LW 5 cycles.
- Each mem_ready-low cycle in FETCH/MEMRD/MEMWR adds one cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Reset mid-instruction: immediate return to IDLE with no further enables.
  - A register write in flight is lost if reset is asserted before the clock edge of the writeback state.
- state_o encoding: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXECUTE 7, ALUWB 8, BRANCH 9, ADDIEXEC 10, ADDIWB 11, JUMP 12, ILLEGAL 15.

Optional Feature:
- Macro: MIPS_MC_BNE_EN.
- Defined: op 000101 (BNE) in DECODE -> BRANCH. BRANCH drives pcen=~zero for BNE and pcen=zero for BEQ, selected by op. Latency 3 cycles; counted as retired.
- Undefined: op 000101 -> ILLEGAL.

Test Plan:
- Reset released, mem_ready=1 -> state_o 0 then 1; FETCH asserts mem_req=1, irwrite=1, pcen=1, alusrcb=01; instr_count=0.
- op=000000 funct=100010 -> EXECUTE alucontrol=110, then ALUWB regwrite=1, regdst=1; 4 cycles; instr_count +1.
- op=100011 with mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles with iord=1, then MEMWB memtoreg=1, regwrite=1; total 7 cycles.
- op=000100: zero=1 -> pcen=1, pcsrc=01 in BRANCH; zero=0 -> pcen=0; both take 3 cycles and both increment instr_count.
- op=111111, or op=000000 with funct=000000 -> ILLEGAL; illegal_op=1 and stays high 10+ cycles; mem_req=0; instr_count frozen; reset clears it.
- op=000101: with MIPS_MC_BNE_EN, zero=0 -> pcen=1; without the macro -> ILLEGAL.

Source files
------------

// File: rtl/mips_mc_if.sv
// Control bundle between the multicycle MIPS controller and its datapath and
// shared memory. The controller uses the master side; the datapath or a test
// harness uses the slave side.
interface mips_mc_if #(
  parameter int CNT_W = 32
);
  // Instruction fields and datapath status
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  // Shared memory handshake
  logic             mem_ready;
  logic             mem_req;
  logic             memwrite;
  // Datapath steering
  logic             iord;
  logic             irwrite;
  logic             pcen;
  logic [1:0]       pcsrc;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [2:0]       alucontrol;
  logic             regdst;
  logic             memtoreg;
  logic             regwrite;
  // Status
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state_o;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           alucontrol, regdst, memtoreg, regwrite, illegal_op, instr_count,
           state_o
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           alucontrol, regdst, memtoreg, regwrite, illegal_op, instr_count,
           state_o
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM for a datapath with one shared instruction/data
// memory. Sequences fetch/decode/execute/memory/writeback, counts retired
// instructions and traps illegal opcodes into an absorbing state.
// Optional build macro MIPS_MC_BNE_EN adds BNE (op 000101) through the BRANCH
// state; without it BNE is trapped as illegal.
module mips_mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic     clk,
  input  logic     reset,
  mips_mc_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // R-type function field to ALU operation; unsupported codes never reach
  // EXECUTE, so the default is only a safe filler.
  function automatic logic [2:0] alu_from_funct(input logic [5:0] f);
    case (f)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic funct_supported(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] instr_cnt;
  logic             retire;

  logic       mem_req, memwrite, iord, irwrite, pcen;
  logic [1:0] pcsrc, alusrcb;
  logic       alusrca, regdst, memtoreg, regwrite, illegal_op;
  logic [2:0] alucontrol;

  // State register; reset drops straight back to IDLE from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + 1'b1;
  end

  // Next-state and control decode. Moore outputs per state, with irwrite/pcen
  // additionally gated by mem_ready (FETCH) or zero (BRANCH).
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    illegal_op = 1'b0;

    case (state)
      S_IDLE: begin
        next_state = S_FETCH;
      end

      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        if (bus.mem_ready) begin
          irwrite    = 1'b1;
          pcen       = 1'b1;
          next_state = S_DECODE;
        end
      end

      // Precompute the branch target into ALUOut while the opcode is decoded.
      S_DECODE: begin
        alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = funct_supported(bus.funct) ? S_EXECUTE : S_ILLEGAL;
          OP_BEQ:       next_state = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       next_state = S_BRANCH;
`endif
          OP_ADDI:      next_state = S_ADDIEXEC;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_ILLEGAL;
        endcase
      end

      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready) next_state = S_MEMWB;
      end

      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (bus.mem_ready) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end
      end

      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = alu_from_funct(bus.funct);
        next_state = S_ALUWB;
      end

      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      // Compare A and B; the PC takes the target held in ALUOut when taken.
      // Taken or not, the branch retires.
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
`ifdef MIPS_MC_BNE_EN
        pcen       = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
`else
        pcen       = bus.zero;
`endif
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = S_ADDIWB;
      end

      S_ADDIWB: begin
        regwrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_JUMP: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      // Trap: everything quiet, only reset leaves.
      S_ILLEGAL: begin
        illegal_op = 1'b1;
        next_state = S_ILLEGAL;
      end

      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Drive the bundle.
  always_comb begin
    bus.mem_req     = mem_req;
    bus.memwrite    = memwrite;
    bus.iord        = iord;
    bus.irwrite     = irwrite;
    bus.pcen        = pcen;
    bus.pcsrc       = pcsrc;
    bus.alusrca     = alusrca;
    bus.alusrcb     = alusrcb;
    bus.alucontrol  = alucontrol;
    bus.regdst      = regdst;
    bus.memtoreg    = memtoreg;
    bus.regwrite    = regwrite;
    bus.illegal_op  = illegal_op;
    bus.instr_count = instr_cnt;
    bus.state_o     = state;
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Testbench for mips_mc_controller: each driven cycle pushes its expected
// control word onto a queue; a monitor on the falling edge pops and compares.
// Counter is built narrow so its wrap is reached quickly.
module tb_mips_mc_controller;

  localparam int CW = 4;

  typedef struct packed {
    logic [3:0]  st;
    logic        mem_req;
    logic        memwrite;
    logic        iord;
    logic        irwrite;
    logic        pcen;
    logic [1:0]  pcsrc;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [2:0]  aluc;
    logic        regdst;
    logic        memtoreg;
    logic        regwrite;
    logic        illegal;
    logic [31:0] cnt;
  } obs_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [CW-1:0] exp_cnt;
  obs_t exp_q[$];

  mips_mc_if #(.CNT_W(CW)) mc ();

  mips_mc_controller #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", tag, act, req);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st       = mc.state_o;
    o.mem_req  = mc.mem_req;
    o.memwrite = mc.memwrite;
    o.iord     = mc.iord;
    o.irwrite  = mc.irwrite;
    o.pcen     = mc.pcen;
    o.pcsrc    = mc.pcsrc;
    o.alusrca  = mc.alusrca;
    o.alusrcb  = mc.alusrcb;
    o.aluc     = mc.alucontrol;
    o.regdst   = mc.regdst;
    o.memtoreg = mc.memtoreg;
    o.regwrite = mc.regwrite;
    o.illegal  = mc.illegal_op;
    o.cnt      = 32'(mc.instr_count);
    return o;
  endfunction

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      check($sformatf("cyc_st%0d", e.st), 64'(sample()), 64'(e));
    end
  end

  function automatic obs_t blank(input logic [3:0] st);
    obs_t e;
    e      = '0;
    e.st   = st;
    e.aluc = 3'b010;
    return e;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle and queue what the controller must show during it.
  task automatic step(input obs_t e, input logic mr, input logic z);
    mc.mem_ready = mr;
    mc.zero      = z;
    e.cnt        = 32'(exp_cnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    exp_cnt = '0;
    step(blank(4'd0), rnd(), rnd());
    reset   = 1'b0;
    step(blank(4'd0), rnd(), rnd());
  endtask

  task automatic begin_instr(input logic [5:0] op, input logic [5:0] fn, input int fwait);
    obs_t e;
    mc.op    = op;
    mc.funct = fn;
    e = blank(4'd1);
    e.mem_req = 1'b1;
    e.alusrcb = 2'b01;
    repeat (fwait) step(e, 1'b0, rnd());
    e.irwrite = 1'b1;
    e.pcen    = 1'b1;
    step(e, 1'b1, rnd());
    e = blank(4'd2);
    e.alusrcb = 2'b11;
    step(e, rnd(), rnd());
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [2:0] aluc);
    obs_t e;
    begin_instr(6'b000000, fn, 0);
    e = blank(4'd7);
    e.alusrca = 1'b1;
    e.alusrcb = 2'b00;
    e.aluc    = aluc;
    step(e, rnd(), rnd());
    e = blank(4'd8);
    e.regdst   = 1'b1;
    e.regwrite = 1'b1;
    step(e, rnd(), rnd());
    exp_cnt++;
  endtask

  task automatic memadr(input logic [5:0] op, input int fwait);
    obs_t e;
    begin_instr(op, 6'b000000, fwait);
    e = blank(4'd3);
    e.alusrca = 1'b1;
    e.alusrcb = 2'b10;
    step(e, rnd(), rnd());
  endtask

  task automatic lw(input int fwait, input int mwait);
    obs_t e;
    memadr(6'b100011, fwait);
    e = blank(4'd4);
    e.mem_req = 1'b1;
    e.iord    = 1'b1;
    repeat (mwait) step(e, 1'b0, rnd());
    step(e, 1'b1, rnd());
    e = blank(4'd5);
    e.memtoreg = 1'b1;
    e.regwrite = 1'b1;
    step(e, rnd(), rnd());
    exp_cnt++;
  endtask

  task automatic sw(input int mwait);
    obs_t e;
    memadr(6'b101011, 0);
    e = blank(4'd6);
    e.mem_req  = 1'b1;
    e.iord     = 1'b1;
    e.memwrite = 1'b1;
    repeat (mwait) step(e, 1'b0, rnd());
    step(e, 1'b1, rnd());
    exp_cnt++;
  endtask

  task automatic branch(input logic [5:0] op, input logic z, input logic taken);
    obs_t e;
    begin_instr(op, 6'($urandom), 0);
    e = blank(4'd9);
    e.alusrca = 1'b1;
    e.aluc    = 3'b110;
    e.pcsrc   = 2'b01;
    e.pcen    = taken;
    step(e, rnd(), z);
    exp_cnt++;
  endtask

  task automatic addi();
    obs_t e;
    begin_instr(6'b001000, 6'($urandom), 0);
    e = blank(4'd10);
    e.alusrca = 1'b1;
    e.alusrcb = 2'b10;
    step(e, rnd(), rnd());
    e = blank(4'd11);
    e.regwrite = 1'b1;
    step(e, rnd(), rnd());
    exp_cnt++;
  endtask

  task automatic jump();
    obs_t e;
    begin_instr(6'b000010, 6'($urandom), 0);
    e = blank(4'd12);
    e.pcsrc = 2'b10;
    e.pcen  = 1'b1;
    step(e, rnd(), rnd());
    exp_cnt++;
  endtask

  task automatic trap(input logic [5:0] op, input logic [5:0] fn, input int n);
    obs_t e;
    begin_instr(op, fn, 0);
    e = blank(4'd15);
    e.illegal = 1'b1;
    repeat (n) step(e, rnd(), rnd());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total        = 0;
    bad          = 0;
    exp_cnt      = '0;
    reset        = 1'b1;
    mc.op        = 6'd0;
    mc.funct     = 6'd0;
    mc.zero      = 1'b0;
    mc.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(blank(4'd0), rnd(), rnd());
    reset = 1'b0;
    step(blank(4'd0), rnd(), rnd());

    // All ALU R-type operations, SUB first.
    rtype(6'b100010, 3'b110);
    rtype(6'b100000, 3'b010);
    rtype(6'b100100, 3'b000);
    rtype(6'b100101, 3'b001);
    rtype(6'b101010, 3'b111);
    // Loads/stores with memory stalls in fetch and data phases.
    lw(0, 2);
    lw(1, 0);
    sw(0);
    sw(2);
    // Branch taken and not taken both retire.
    branch(6'b000100, 1'b1, 1'b1);
    branch(6'b000100, 1'b0, 1'b0);
    addi();
    jump();
    // Enough additional instructions to wrap the narrow counter.
    for (int i = 0; i < 6; i++) begin
      jump();
      addi();
    end

`ifdef MIPS_MC_BNE_EN
    branch(6'b000101, 1'b0, 1'b1);
    branch(6'b000101, 1'b1, 1'b0);
`else
    trap(6'b000101, 6'b000000, 4);
    do_reset();
`endif

    // Illegal opcode: trap holds with counter frozen until reset.
    jump();
    trap(6'b111111, 6'b000000, 12);
    do_reset();
    // R-type with unsupported function code.
    rtype(6'b100000, 3'b010);
    trap(6'b000000, 6'b000000, 11);
    do_reset();
    // Reset in the middle of a load: no write happens, counter cleared.
    jump();
    memadr(6'b100011, 0);
    do_reset();
    lw(0, 0);
    jump();

    @(negedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
